// File: rtl/kf76489_write_master.sv
// Host-side write initiator for the KF76489: queues register-write commands and strobes
// them out as SN76489 bytes paced by READY. Define KF76489_WRITE_MASTER_TIMEOUT_EN to add timeout_err.
module kf76489_write_master #(
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int READY_WAIT     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_reg,
    input  logic [9:0]                  cmd_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        CE_N,
    output logic                        WE_N,
    output logic [7:0]                  D_OUT,
`ifdef KF76489_WRITE_MASTER_TIMEOUT_EN
    output logic                        timeout_err,
`endif
    input  logic                        READY
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WMAX = (READY_WAIT > TIMEOUT_CYCLES) ? READY_WAIT : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(WMAX + 1);
    localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_LO, WAIT_HI, RELEASE, GAP} state_t;

    logic [12:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, empty, push, pop;

    logic [2:0]    head_reg;
    logic [9:0]    head_data;
    logic [7:0]    head_a, head_b;
    logic          head_two;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_nx;
    logic [3:0]    gap_cnt, gap_nx;
    logic          two_q, two_nx;
    logic          ce_n_nx, we_n_nx, setup_b;
    logic [7:0]    byte_b_q;
`ifdef KF76489_WRITE_MASTER_TIMEOUT_EN
    logic          tmo_hit;
`endif

    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign push       = cmd_valid && !full;
    assign pop        = (state == IDLE) && !empty;
    assign cmd_ready  = !full;
    assign fifo_level = level;
    assign busy       = !empty || (state != IDLE);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {cmd_reg, cmd_data};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Byte expansion of the head command; noise control clears bit3 of the latch byte
    assign {head_reg, head_data} = mem[rd_ptr];
    assign head_b   = {2'b00, head_data[9:4]};
    assign head_two = !head_reg[0] && (head_reg[2:1] != 2'd3);

    always_comb begin
        head_a = {1'b1, head_reg, head_data[3:0]};
        if (head_reg == 3'd6) head_a[3] = 1'b0;
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        gap_nx   = gap_cnt;
        two_nx   = two_q;
`ifdef KF76489_WRITE_MASTER_TIMEOUT_EN
        tmo_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = LOAD;
                    two_nx   = head_two;
                end
            end
            LOAD:   state_nx = STROBE;
            STROBE: begin
                state_nx = WAIT_LO;
                wait_nx  = CW'(1);
            end
            WAIT_LO: begin
                if (!READY) begin
                    state_nx = WAIT_HI;
                    wait_nx  = CW'(1);
                end else if (wait_cnt == CW'(READY_WAIT)) begin
                    state_nx = RELEASE;
                end else begin
                    wait_nx = wait_cnt + CW'(1);
                end
            end
            WAIT_HI: begin
                if (READY) begin
                    state_nx = RELEASE;
                end
`ifdef KF76489_WRITE_MASTER_TIMEOUT_EN
                else if (wait_cnt == CW'(TIMEOUT_CYCLES)) begin
                    state_nx = RELEASE;
                    two_nx   = 1'b0;
                    tmo_hit  = 1'b1;
                end else begin
                    wait_nx = wait_cnt + CW'(1);
                end
`endif
            end
            RELEASE: begin
                state_nx = GAP;
                gap_nx   = 4'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nx = two_q ? STROBE : IDLE;
                    two_nx   = 1'b0;
                end else begin
                    gap_nx = gap_cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from the next state so each pin is glitch-free for the whole state
        setup_b = (state_nx == GAP) && (gap_nx == 4'd0) && two_nx;
        ce_n_nx = !(state_nx inside {STROBE, WAIT_LO, WAIT_HI});
        we_n_nx = !((state_nx inside {LOAD, STROBE, WAIT_LO, WAIT_HI}) || setup_b);
    end

    always_ff @(posedge clock) begin
        if (pop) byte_b_q <= head_b;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            two_q    <= 1'b0;
            CE_N     <= 1'b1;
            WE_N     <= 1'b1;
            D_OUT    <= 8'h00;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            gap_cnt  <= gap_nx;
            two_q    <= two_nx;
            CE_N     <= ce_n_nx;
            WE_N     <= we_n_nx;
            if (pop)          D_OUT <= head_a;
            else if (setup_b) D_OUT <= byte_b_q;
        end
    end

`ifdef KF76489_WRITE_MASTER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    timeout_err <= 1'b0;
        else if (tmo_hit) timeout_err <= 1'b1;
        else if (push)    timeout_err <= 1'b0;
    end
`endif

endmodule
